// File: rtl/rom_load_seq_if.sv
// ROM download bus between hps_io and the core.
// The ioctl_* byte stream comes in and the registered dn_* write port goes out.
interface rom_load_seq_if;
  logic        ioctl_download;
  logic        ioctl_wr;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic [15:0] dn_addr;
  logic [7:0]  dn_data;
  logic        dn_wr;
  logic [2:0]  dn_region;

  // hps_io side: drives the download stream and watches the core write port
  modport master (
    output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    input  dn_addr, dn_data, dn_wr, dn_region
  );

  // sequencer side: consumes the download stream and drives the core write port
  modport slave (
    input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout,
    output dn_addr, dn_data, dn_wr, dn_region
  );
endinterface

// File: rtl/rom_load_seq.sv
// ROM download sequencer for the ladybug core.
// Routes each downloaded byte to the CPU, graphics or colour PROM region.
// Checks that the image is complete, and owns the core reset: reset is held
// until a good image is in, then stretched by a fixed settle time.
module rom_load_seq #(
  parameter logic [15:0] CPU_END  = 16'h8000,
  parameter logic [15:0] GFX_END  = 16'hA000,
  parameter logic [15:0] PROM_END = 16'hA060,
  parameter logic [16:0] EXP_SIZE = 17'h0A060,
  parameter int          HOLD_CYC = 1024
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          user_reset,
  rom_load_seq_if.slave bus,
  output logic          core_reset,
  output logic          load_ok,
  output logic          load_err,
  output logic [16:0]   byte_cnt
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;
  localparam logic [1:0] ST_RUN  = 2'd3;

  localparam int             CNT_W     = $clog2(HOLD_CYC);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] hold_cnt;
  logic             oor;
  logic             addr_in_range;
  logic [2:0]       region_sel;
  logic             load_wr;
  logic             dn_wr_q;
  logic [15:0]      dn_addr_q;
  logic [7:0]       dn_data_q;
  logic [2:0]       dn_region_q;

  // Decode the incoming byte address into range check and one-hot region
  always_comb begin
    addr_in_range = (bus.ioctl_addr[24:16] == 9'd0) &&
                    (bus.ioctl_addr[15:0] < PROM_END);
    if (bus.ioctl_addr[15:0] < CPU_END) begin
      region_sel = 3'b001;
    end else if (bus.ioctl_addr[15:0] < GFX_END) begin
      region_sel = 3'b010;
    end else begin
      region_sel = 3'b100;
    end
  end

  // Writes only count while loading; the cycle that sees download low is the exit cycle
  assign load_wr = (state == ST_LOAD) && bus.ioctl_download && bus.ioctl_wr;

  // The core runs only in RUN, so reset follows the registered state
  assign core_reset = (state != ST_RUN);

  // Load / hold / run sequencing, byte counting and the load verdict
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= ST_BOOT;
      hold_cnt <= HOLD_LAST;
      oor      <= 1'b0;
      load_ok  <= 1'b0;
      load_err <= 1'b0;
      byte_cnt <= 17'd0;
    end else begin
      case (state)
        ST_BOOT: begin
          if (bus.ioctl_download) begin
            state    <= ST_LOAD;
            byte_cnt <= 17'd0;
            oor      <= 1'b0;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (!bus.ioctl_download) begin
            if ((byte_cnt == EXP_SIZE) && !oor) begin
              load_ok  <= 1'b1;
              hold_cnt <= HOLD_LAST;
              state    <= ST_HOLD;
            end else begin
              load_err <= 1'b1;
              state    <= ST_BOOT;
            end
          end else if (bus.ioctl_wr) begin
            if (addr_in_range) begin
              if (byte_cnt != 17'h1FFFF) begin
                byte_cnt <= byte_cnt + 17'd1;
              end
            end else begin
              oor <= 1'b1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.ioctl_download) begin
            state    <= ST_LOAD;
            byte_cnt <= 17'd0;
            oor      <= 1'b0;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
          end else if (user_reset) begin
            hold_cnt <= HOLD_LAST;
          end else if (hold_cnt == '0) begin
            state <= ST_RUN;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        ST_RUN: begin
          if (bus.ioctl_download) begin
            state    <= ST_LOAD;
            byte_cnt <= 17'd0;
            oor      <= 1'b0;
            load_ok  <= 1'b0;
            load_err <= 1'b0;
          end else if (user_reset) begin
            hold_cnt <= HOLD_LAST;
            state    <= ST_HOLD;
          end
        end
        default: state <= ST_BOOT;
      endcase
    end
  end

  // Registered core write port: one strobe per accepted in-range byte
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dn_wr_q     <= 1'b0;
      dn_addr_q   <= 16'd0;
      dn_data_q   <= 8'd0;
      dn_region_q <= 3'd0;
    end else begin
      dn_wr_q <= load_wr && addr_in_range;
      if (load_wr && addr_in_range) begin
        dn_addr_q   <= bus.ioctl_addr[15:0];
        dn_data_q   <= bus.ioctl_dout;
        dn_region_q <= region_sel;
      end
    end
  end

  assign bus.dn_wr     = dn_wr_q;
  assign bus.dn_addr   = dn_addr_q;
  assign bus.dn_data   = dn_data_q;
  assign bus.dn_region = dn_region_q;

endmodule
